seg_bcd_scan: RTL and testbench

SEG_BCD_SCAN -- requirements
Module: seg_bcd_scan

---
 rtl/seg_bcd_scan.sv | 153 +++++++++++++++
 tb/tb_seg_bcd_scan.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_scan.sv
// rtl/seg_bcd_scan.sv - sequential double-dabble binary-to-BCD converter driving a 6-digit multiplexed 7-segment display
module seg_bcd_scan #(
    parameter int SCAN_CNT = 100000
) (
    input  logic        CLK_50M,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_en,
    input  logic        disp_off,
    output logic        busy,
    output logic        done,
    output logic [6:1]  SEG_NCS,
    output logic [7:0]  SEG_LED
);

    localparam int SCAN_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CNT - 1);
    localparam logic [4:0] LAST_SHIFT = 5'd16;

    // Conversion state
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;

    // Display buffer: five live BCD digits; the hundred-thousands digit is always 0
    logic [19:0] disp_q, disp_d;

    // Scan state
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        dig_idx_q, dig_idx_d;
    logic [6:1]        ncs_q, ncs_d;
    logic [7:0]        led_q, led_d;

    logic       wrap;
    logic [3:0] cur_digit;
    logic       lead_zero;

    function automatic logic [19:0] dd_adjust(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int k = 0; k < 5; k++) begin
            if (r[k*4 +: 4] >= 4'd5) begin
                r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        disp_d    = disp_q;
        if (!busy_q) begin
            if (load) begin
                bin_d     = value;
                bcd_d     = 20'd0;
                bit_cnt_d = 5'd0;
                busy_d    = 1'b1;
            end
        end else if (bit_cnt_q == LAST_SHIFT) begin
            // Buffer is only written once all shifts are done, so the scan never shows partial digits
            disp_d = bcd_q;
            done_d = 1'b1;
            busy_d = 1'b0;
        end else begin
            {bcd_d, bin_d} = {dd_adjust(bcd_q), bin_q} << 1;
            bit_cnt_d      = bit_cnt_q + 5'd1;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        lead_zero = 1'b0;
        case (dig_idx_q)
            3'd1: begin cur_digit = 4'd0;          lead_zero = 1'b1;                 end
            3'd2: begin cur_digit = disp_q[19:16]; lead_zero = (disp_q[19:16] == 4'd0); end
            3'd3: begin cur_digit = disp_q[15:12]; lead_zero = (disp_q[19:12] == 8'd0); end
            3'd4: begin cur_digit = disp_q[11:8];  lead_zero = (disp_q[19:8] == 12'd0); end
            3'd5: begin cur_digit = disp_q[7:4];   lead_zero = (disp_q[19:4] == 16'd0); end
            3'd6: begin cur_digit = disp_q[3:0];   lead_zero = 1'b0;                 end
            default: begin cur_digit = 4'd0;       lead_zero = 1'b0;                 end
        endcase
    end

    always_comb begin
        wrap       = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        dig_idx_d  = dig_idx_q;
        ncs_d      = ncs_q;
        led_d      = led_q;
        if (wrap) begin
            ncs_d     = disp_off ? 6'b111111 : ~(6'b000001 << (dig_idx_q - 3'd1));
            led_d     = (blank_en && lead_zero) ? 8'hFF : seg_code(cur_digit);
            dig_idx_d = (dig_idx_q == 3'd6) ? 3'd1 : dig_idx_q + 3'd1;
        end
    end

    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= 16'd0;
            bcd_q      <= 20'd0;
            bit_cnt_q  <= 5'd0;
            disp_q     <= 20'd0;
            scan_cnt_q <= '0;
            dig_idx_q  <= 3'd1;
            ncs_q      <= 6'b111111;
            led_q      <= 8'hFF;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bit_cnt_q  <= bit_cnt_d;
            disp_q     <= disp_d;
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            ncs_q      <= ncs_d;
            led_q      <= led_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign SEG_NCS = ncs_q;
    assign SEG_LED = led_q;

endmodule

// File: tb/tb_seg_bcd_scan.sv
// tb/tb_seg_bcd_scan.sv - directed self-checking bench for seg_bcd_scan
module tb_seg_bcd_scan;

    logic        CLK_50M;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        blank_en;
    logic        disp_off;
    logic        busy;
    logic        done;
    logic [6:1]  SEG_NCS;
    logic [7:0]  SEG_LED;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    seg_bcd_scan #(.SCAN_CNT(4)) dut (
        .CLK_50M (CLK_50M),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .blank_en(blank_en),
        .disp_off(disp_off),
        .busy    (busy),
        .done    (done),
        .SEG_NCS (SEG_NCS),
        .SEG_LED (SEG_LED)
    );

    initial CLK_50M = 1'b0;
    always #5 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic sync_idx1();
        int n;
        n = 0;
        while (SEG_NCS == 6'b111110 && n < 100) begin @(negedge CLK_50M); n++; end
        while (SEG_NCS != 6'b111110 && n < 100) begin @(negedge CLK_50M); n++; end
        if (n >= 100) chk("sync_timeout", 32'd1, 32'd0);
    endtask

    // e[47:40] is the leftmost digit pattern, e[7:0] the ones digit
    task automatic scan_check(input string tag, input logic [47:0] e);
        logic [5:0] ncs_exp;
        sync_idx1();
        for (int k = 0; k < 6; k++) begin
            ncs_exp = ~(6'b000001 << k);
            chk({tag, "_ncs"}, {26'd0, SEG_NCS}, {26'd0, ncs_exp});
            chk({tag, "_led"}, {24'd0, SEG_LED}, {24'd0, e[47-8*k -: 8]});
            repeat (4) @(negedge CLK_50M);
        end
    endtask

    task automatic conv(input logic [15:0] v, input int ign_at);
        int first_done;
        first_done = 0;
        chk("idle_before_load", {31'd0, busy}, 32'd0);
        load  = 1'b1;
        value = v;
        @(negedge CLK_50M);
        load  = 1'b0;
        value = 16'hA5A5;
        chk("busy_after_load", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 17; i++) begin
            if (ign_at > 0 && i == ign_at) begin
                load  = 1'b1;
                value = 16'h0001;
            end
            @(negedge CLK_50M);
            load = 1'b0;
            if (done && first_done == 0) first_done = i;
        end
        chk("done_edge", first_done, 32'd17);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dcnt;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'd0;
        blank_en = 1'b1;
        disp_off = 1'b0;
        repeat (3) @(negedge CLK_50M);
        chk("rst_ncs",  {26'd0, SEG_NCS}, 32'h3F);
        chk("rst_led",  {24'd0, SEG_LED}, 32'hFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge CLK_50M);
        chk("pre_wrap_ncs", {26'd0, SEG_NCS}, 32'h3F);
        @(negedge CLK_50M);
        chk("first_wrap_ncs", {26'd0, SEG_NCS}, 32'h3E);
        chk("first_wrap_led", {24'd0, SEG_LED}, 32'hFF);

        // 12345 with blanking
        conv(16'h3039, 0);
        scan_check("d12345", {8'hFF, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49});

        // disp_off for 12 cycles starting right after the leftmost-digit wrap
        sync_idx1();
        disp_off = 1'b1;
        for (int s = 0; s < 3; s++) begin
            repeat (4) @(negedge CLK_50M);
            chk("off_ncs", {26'd0, SEG_NCS}, 32'h3F);
        end
        disp_off = 1'b0;
        repeat (4) @(negedge CLK_50M);
        chk("resume_ncs5", {26'd0, SEG_NCS}, 32'h2F);
        chk("resume_led5", {24'd0, SEG_LED}, 32'h99);
        repeat (4) @(negedge CLK_50M);
        chk("resume_ncs6", {26'd0, SEG_NCS}, 32'h1F);
        chk("resume_led6", {24'd0, SEG_LED}, 32'h49);

        // 65535 without blanking
        blank_en = 1'b0;
        conv(16'hFFFF, 0);
        scan_check("d65535", {8'h03, 8'h41, 8'h49, 8'h49, 8'h0D, 8'h49});

        // back-to-back: second load lands in the done cycle
        blank_en = 1'b1;
        conv(16'h1234, 0);
        chk("done_pulse_chain", {31'd0, done}, 32'd1);
        conv(16'h0000, 0);
        @(negedge CLK_50M);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        scan_check("d0", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03});

        // load during busy ignored
        conv(16'h0064, 5);
        scan_check("d100", {8'hFF, 8'hFF, 8'hFF, 8'h9F, 8'h03, 8'h03});

        // reset mid-conversion
        blank_en = 1'b0;
        load  = 1'b1;
        value = 16'h1234;
        @(negedge CLK_50M);
        load = 1'b0;
        repeat (8) @(negedge CLK_50M);
        rst_n = 1'b0;
        #1;
        chk("abort_ncs",  {26'd0, SEG_NCS}, 32'h3F);
        chk("abort_led",  {24'd0, SEG_LED}, 32'hFF);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge CLK_50M);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK_50M);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);
        scan_check("dbuf0", {8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03});

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
